// File: rtl/seq_chunk_adder_pkg.sv
// ============================================================================
// Module  : seq_chunk_adder_pkg
// Brief   : State encoding and a width helper shared by the chunked adder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never less than 1 so a single-chunk counter still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chunk_adder_rca_chunk.sv
// ============================================================================
// Module  : seq_chunk_adder_rca_chunk
// Brief   : CHUNK-bit combinational ripple-carry adder built from full adders.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_chunk_adder_rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_ci;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_co = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// ============================================================================
// Module  : seq_chunk_adder
// Brief   : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through
//           one shared ripple stage, with a start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = clog2_min1(NCHUNK);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;
  logic             r_done;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_last    = (r_cnt == CW'(NCHUNK - 1));

  seq_chunk_adder_rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca (
    .i_a  (w_a_chunk),
    .i_b  (w_b_chunk),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // subtraction is a + ~b + 1, so the inverted b and forced carry are latched
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_ci;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_s[r_cnt*CHUNK +: CHUNK] <= w_sum;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // the top chunk's sum is not in r_s yet, so take its MSB from the stage
            r_co    <= w_cout;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (r_state == ST_BUSY);
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_co   = r_co;
  assign o_ovf  = r_ovf;

endmodule

`default_nettype wire
